// File: rtl/pdata_pkg.sv
// pdata_pkg: PE opcode encoding and per-opcode shift length.
// Shared by the PE, the host-side controller and the bench.
package pdata_pkg;

  localparam logic [2:0] OUT_DATA1 = 3'd0;
  localparam logic [2:0] OUT_DATA2 = 3'd1;
  localparam logic [2:0] OUT_RES   = 3'd2;
  localparam logic [2:0] LOAD      = 3'd3;
  localparam logic [2:0] LOAD_RES  = 3'd4;
  localparam logic [2:0] MUL       = 3'd5;
  localparam logic [2:0] MUL_ADD   = 3'd6;
  localparam logic [2:0] NO_OP     = 3'd7;

  // Number of PE clock cycles an opcode must be held on the bus.
  function automatic int unsigned N(input logic [2:0] op, input int unsigned size);
    case (op)
      OUT_DATA1, OUT_DATA2: return size;
      OUT_RES:              return 4 * size;
      LOAD:                 return 2 * size;
      LOAD_RES:             return 4 * size;
      MUL, MUL_ADD:         return 1;
      default:              return 0;
    endcase
  endfunction

  function automatic logic is_out(input logic [2:0] op);
    return (op == OUT_DATA1) || (op == OUT_DATA2) || (op == OUT_RES);
  endfunction

endpackage

// File: rtl/pdata_ser.sv
// pdata_ser: W-bit shift register feeding the PE serial input (MSB- or LSB-first)
// plus an indexed capture register assembling the PE serial output.
module pdata_ser #(
  parameter int unsigned W  = 128,
  parameter int unsigned IW = 8
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          i_load,
  input  logic [W-1:0]  i_load_data,
  input  logic          i_shift,
  input  logic          i_msb_first,
  output logic          o_next,
  input  logic          i_cap_clr,
  input  logic          i_cap_en,
  input  logic [IW-1:0] i_cap_idx,
  input  logic          i_cap_bit,
  output logic [W-1:0]  o_cap
);

  logic [W-1:0] r_sh;
  logic [W-1:0] r_cap;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_load_data;
    end else if (i_shift) begin
      if (i_msb_first) r_sh <= {r_sh[W-2:0], 1'b0};
      else             r_sh <= {1'b0, r_sh[W-1:1]};
    end
  end

  // Bit that becomes the head after the next shift; the controller registers it onto pe_rx.
  assign o_next = i_msb_first ? r_sh[W-2] : r_sh[1];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cap <= '0;
    end else if (i_cap_clr) begin
      r_cap <= '0;
    end else if (i_cap_en) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (i_cap_idx == IW'(i)) r_cap[i] <= i_cap_bit;
      end
    end
  end

  assign o_cap = r_cap;

endmodule

// File: rtl/pdata_ctrl.sv
// pdata_ctrl: host-side sequencer for one bit-serial pdata PE (IDLE -> SHIFT -> RESP).
// Optional macro PDATA_CTRL_STATS_EN adds a saturating response counter op_count.
module pdata_ctrl
  import pdata_pkg::*;
#(
  parameter  int unsigned SIZE = 32,
  localparam int unsigned CW   = $clog2(4*SIZE+1)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [4*SIZE-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [4*SIZE-1:0] resp_data,
  output logic [2:0]        pe_opcode,
  output logic              pe_rx,
  input  logic              pe_tx
`ifdef PDATA_CTRL_STATS_EN
  ,
  output logic [15:0]       op_count
`endif
);

  localparam int unsigned W = 4 * SIZE;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]    r_state;
  logic [2:0]    r_op;
  logic [2:0]    r_opcode;
  logic          r_rx;
  logic          r_cmd_ready;
  logic          r_resp_valid;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_len;
  logic          r_msb;

  logic          w_accept;
  logic          w_resp_hs;
  logic [CW-1:0] w_n;
  logic [W-1:0]  w_align;
  logic          w_msb;
  logic          w_first;
  logic          w_next;
  logic          w_cap_en;
  logic [CW-1:0] w_idx;

  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_resp_hs = r_resp_valid && resp_ready;
  assign w_n       = CW'(N(cmd_op, SIZE));
  assign w_msb     = (cmd_op == LOAD) || (cmd_op == LOAD_RES);

  // LOAD sends only the low 2*SIZE bits MSB first, so park them at the top of the register.
  always_comb begin
    w_align = '0;
    case (cmd_op)
      LOAD:                 w_align = {cmd_data[2*SIZE-1:0], {(2*SIZE){1'b0}}};
      LOAD_RES:             w_align = cmd_data;
      OUT_DATA1, OUT_DATA2: w_align = cmd_data;
      default:              w_align = '0;
    endcase
  end

  assign w_first  = w_msb ? w_align[W-1] : w_align[0];
  assign w_cap_en = (r_state == ST_SHIFT) && is_out(r_op);
  assign w_idx    = r_len - r_cnt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state      <= ST_IDLE;
      r_op         <= NO_OP;
      r_opcode     <= NO_OP;
      r_rx         <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_cnt        <= '0;
      r_len        <= '0;
      r_msb        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op        <= cmd_op;
            r_cnt       <= w_n;
            r_len       <= w_n;
            r_msb       <= w_msb;
            r_cmd_ready <= 1'b0;
            if (cmd_op == NO_OP) begin
              r_state <= ST_RESP;
            end else begin
              r_state  <= ST_SHIFT;
              r_opcode <= cmd_op;
              r_rx     <= w_first;
            end
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_opcode <= NO_OP;
            r_rx     <= 1'b0;
            r_state  <= ST_RESP;
          end else begin
            r_rx <= w_next;
          end
        end
        ST_RESP: begin
          // resp_valid lags state entry by one edge, giving the N+1 cycle latency.
          if (w_resp_hs) begin
            r_resp_valid <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_resp_valid <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_opcode     <= NO_OP;
          r_rx         <= 1'b0;
          r_cmd_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  pdata_ser #(
    .W  (W),
    .IW (CW)
  ) u_ser (
    .clk         (clk),
    .nRst        (nRst),
    .i_load      (w_accept),
    .i_load_data (w_align),
    .i_shift     (r_state == ST_SHIFT),
    .i_msb_first (r_msb),
    .o_next      (w_next),
    .i_cap_clr   (w_accept),
    .i_cap_en    (w_cap_en),
    .i_cap_idx   (w_idx),
    .i_cap_bit   (pe_tx),
    .o_cap       (resp_data)
  );

  assign cmd_ready  = r_cmd_ready;
  assign resp_valid = r_resp_valid;
  assign pe_opcode  = r_opcode;
  assign pe_rx      = r_rx;

`ifdef PDATA_CTRL_STATS_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_op_count <= '0;
    end else if (w_resp_hs && (r_op_count != '1)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_pdata_ctrl.sv
// tb_pdata_ctrl: drives pdata_ctrl (SIZE=8) against a behavioural bit-serial PE and
// scoreboards responses, latency and opcode-bus occupancy.
module tb_pdata_ctrl;
  import pdata_pkg::*;

  localparam int unsigned SIZE = 8;

  logic        clk;
  logic        nRst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [2:0]  pe_opcode;
  logic        pe_rx;
  logic        pe_tx;
`ifdef PDATA_CTRL_STATS_EN
  logic [15:0] op_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;
  logic [31:0] q_exp[$];

  pdata_ctrl #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .pe_opcode  (pe_opcode),
    .pe_rx      (pe_rx),
    .pe_tx      (pe_tx)
`ifdef PDATA_CTRL_STATS_EN
    ,
    .op_count   (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE: shifts on the same edge the controller samples pe_tx.
  logic [7:0]  pe_d1, pe_d2;
  logic [31:0] pe_res;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pe_d1  <= '0;
      pe_d2  <= '0;
      pe_res <= '0;
    end else begin
      case (pe_opcode)
        OUT_DATA1: pe_d1  <= {pe_rx, pe_d1[7:1]};
        OUT_DATA2: pe_d2  <= {pe_rx, pe_d2[7:1]};
        OUT_RES:   pe_res <= {pe_rx, pe_res[31:1]};
        LOAD:      {pe_d2, pe_d1} <= {pe_d2[6:0], pe_d1, pe_rx};
        LOAD_RES:  pe_res <= {pe_res[30:0], pe_rx};
        MUL:       pe_res <= 32'(pe_d1) * 32'(pe_d2);
        MUL_ADD:   pe_res <= pe_res + 32'(pe_d1) * 32'(pe_d2);
        default:   ;
      endcase
    end
  end

  assign pe_tx = (pe_opcode == OUT_DATA1) ? pe_d1[0] :
                 (pe_opcode == OUT_DATA2) ? pe_d2[0] :
                 (pe_opcode == OUT_RES)   ? pe_res[0] : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Scoreboard: pop on each response handshake.
  always @(negedge clk) begin
    if (nRst && resp_valid && resp_ready) begin
      if (q_exp.size() == 0) begin
        timeout("resp_unexpected");
      end else begin
        check("resp_data", resp_data, q_exp.pop_front());
        n_hs++;
      end
    end
  end

  task automatic do_cmd(input string name, input logic [2:0] op, input logic [31:0] data,
                        input logic [31:0] exp, input int unsigned lat);
    int unsigned t, j, opc, bad;
    bit got;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    q_exp.push_back(exp);
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      timeout({name, "_accept"});
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    got = 0; j = 0; opc = 0; bad = 0;
    while (!got && j < 200) begin
      @(negedge clk);
      if (pe_opcode != NO_OP) begin
        opc++;
        if (pe_opcode != op) bad++;
      end
      if (resp_valid) got = 1;
      else j++;
    end
    if (!got) begin
      timeout({name, "_resp"});
      return;
    end
    check({name, "_latency"}, j, lat);
    check({name, "_opcode_cycles"}, opc, lat - 1);
    check({name, "_opcode_value"}, bad, 0);
    t = 0;
    while (resp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (resp_valid) timeout({name, "_handshake"});
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] data;
    logic [31:0] exp;
    int unsigned lat;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int unsigned t;

    vecs[0]  = '{"load_a53c",   LOAD,      32'h0000A53C, 32'h00000000, 17};
    vecs[1]  = '{"out_d1",      OUT_DATA1, 32'h00000000, 32'h0000003C, 9};
    vecs[2]  = '{"out_d2",      OUT_DATA2, 32'h00000000, 32'h000000A5, 9};
    vecs[3]  = '{"out_d1_wr5a", OUT_DATA1, 32'h0000005A, 32'h00000000, 9};
    vecs[4]  = '{"out_d1_rd5a", OUT_DATA1, 32'h00000000, 32'h0000005A, 9};
    vecs[5]  = '{"load_0503",   LOAD,      32'h00000503, 32'h00000000, 17};
    vecs[6]  = '{"mul",         MUL,       32'h00000000, 32'h00000000, 2};
    vecs[7]  = '{"out_res_0f",  OUT_RES,   32'h00000000, 32'h0000000F, 33};
    vecs[8]  = '{"load_res_10", LOAD_RES,  32'h00000010, 32'h00000000, 33};
    vecs[9]  = '{"load_0203",   LOAD,      32'h00000203, 32'h00000000, 17};
    vecs[10] = '{"mul_add",     MUL_ADD,   32'h00000000, 32'h00000000, 2};
    vecs[11] = '{"out_res_16",  OUT_RES,   32'h00000000, 32'h00000016, 33};
    vecs[12] = '{"no_op",       NO_OP,     32'hFFFFFFFF, 32'h00000000, 1};
    vecs[13] = '{"load_res_db", LOAD_RES,  32'hDEADBEEF, 32'h00000000, 33};
    vecs[14] = '{"out_res_db",  OUT_RES,   32'h00000000, 32'hDEADBEEF, 33};
    vecs[15] = '{"load_c35a",   LOAD,      32'hFFFFC35A, 32'h00000000, 17};
    vecs[16] = '{"out_d2_wr77", OUT_DATA2, 32'h00000077, 32'h000000C3, 9};
    vecs[17] = '{"mul_77x5a",   MUL,       32'h00000000, 32'h00000000, 2};
    vecs[18] = '{"out_res_mul", OUT_RES,   32'h00000000, 32'h000029D6, 33};

    nRst       = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = NO_OP;
    cmd_data   = '0;
    resp_ready = 1'b1;
    #1 nRst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pe_opcode", 32'(pe_opcode), 32'h7);
    check("rst_pe_rx", 32'(pe_rx), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    @(posedge clk); #1 nRst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      do_cmd(vecs[i].name, vecs[i].op, vecs[i].data, vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: response held while a second command waits.
    do_cmd("load_1122", LOAD, 32'h00001122, 32'h0, 17);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    cmd_valid  = 1'b1;
    cmd_op     = OUT_DATA2;
    cmd_data   = '0;
    q_exp.push_back(32'h00000011);
    @(negedge clk);
    check("bp_first_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    cmd_op = OUT_DATA1;
    q_exp.push_back(32'h00000022);
    t = 0;
    while (!resp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!resp_valid) timeout("bp_resp");
    repeat (5) begin
      @(negedge clk);
      check("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      check("bp_resp_valid", 32'(resp_valid), 32'h1);
      check("bp_resp_stable", resp_data, 32'h00000011);
      check("bp_no_accept", 32'(pe_opcode), 32'h7);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_hs_ready", 32'(cmd_ready), 32'h1);
    check("bp_hs_valid", 32'(resp_valid), 32'h0);
    check("bp_hs_opcode", 32'(pe_opcode), 32'h7);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_second_opcode", 32'(pe_opcode), 32'(OUT_DATA1));
    check("bp_second_ready", 32'(cmd_ready), 32'h0);
    t = 0;
    while ((q_exp.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q_exp.size() != 0) timeout("bp_second_resp");
    @(negedge clk);

    // Reset in the middle of an OUT_RES shift.
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = OUT_RES;
    cmd_data  = '0;
    @(negedge clk);
    check("rst_mid_accept_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_shifting", 32'(pe_opcode), 32'(OUT_RES));
    nRst = 1'b0;
    #1;
    check("rst_mid_pe_opcode", 32'(pe_opcode), 32'h7);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_mid_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_mid_resp_data", resp_data, 32'h0);
    check("rst_mid_pe_rx", 32'(pe_rx), 32'h0);
    @(posedge clk); #1 nRst = 1'b1;
    n_hs = 0;

    do_cmd("post_rst_load", LOAD, 32'h00006699, 32'h0, 17);
    do_cmd("post_rst_out_d1", OUT_DATA1, 32'h0, 32'h00000099, 9);
    do_cmd("post_rst_no_op", NO_OP, 32'h0, 32'h0, 1);

`ifdef PDATA_CTRL_STATS_EN
    @(negedge clk);
    check("op_count", 32'(op_count), 32'(n_hs));
`endif

    check("queue_empty", 32'(q_exp.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
